// File: rtl/iter_alu.sv
// Iterative integer ALU: single-cycle logic/add ops, WIDTH-cycle shift-add
// multiply and restoring divide on operand magnitudes with final sign fix-up.
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state_reg;
   logic [SW-1:0]    cnt_reg;
   logic [3:0]       op_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg, b_reg, result_reg;
   logic             neg_q_reg, neg_r_reg, zero_reg, done_reg, busy_reg;

   logic [WIDTH-1:0] quick_res, a_mag, b_mag, hi_next, lo_next, fin_res;
   logic [WIDTH-1:0] div_q, div_r;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic             is_multi, is_sdiv, a_neg, b_neg, mul_op;

   always_comb begin
      quick_res = '0;
      case (op)
         4'd0: quick_res = srcA + srcB;
         4'd1: quick_res = srcA - srcB;
         4'd2: quick_res = srcA & srcB;
         4'd3: quick_res = srcA | srcB;
         4'd4: quick_res = srcA ^ srcB;
         4'd5: quick_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
         4'd6: quick_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
         4'd7: quick_res = srcA << srcB[SW-1:0];
         default: quick_res = '0;
      endcase
   end

   // Signed divide runs on magnitudes; signs are remembered for the FIN edge.
   assign is_multi = (op >= 4'd8) && (op <= 4'd13);
   assign is_sdiv  = (op == 4'd12) || (op == 4'd13);
   assign a_neg    = is_sdiv & srcA[WIDTH-1];
   assign b_neg    = is_sdiv & srcB[WIDTH-1];
   assign a_mag    = a_neg ? -srcA : srcA;
   assign b_mag    = b_neg ? -srcB : srcB;

   assign mul_op    = (op_reg == 4'd8) || (op_reg == 4'd9);
   assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
   assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_reg};

   always_comb begin
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (mul_op) begin
         hi_next = mul_sum[WIDTH:1];
         lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         hi_next = div_diff[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
         hi_next = div_shift[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
   end

   assign div_q = neg_q_reg ? -lo_reg : lo_reg;
   assign div_r = neg_r_reg ? -hi_reg : hi_reg;

   always_comb begin
      fin_res = '0;
      case (op_reg)
         4'd8, 4'd10: fin_res = lo_reg;
         4'd9, 4'd11: fin_res = hi_reg;
         4'd12:       fin_res = div_q;
         4'd13:       fin_res = div_r;
         default:     fin_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_reg     <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         b_reg      <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (is_multi) begin
                     op_reg    <= op;
                     hi_reg    <= '0;
                     lo_reg    <= a_mag;
                     b_reg     <= b_mag;
                     // Divide by zero keeps the all-ones quotient unsigned.
                     neg_q_reg <= (a_neg ^ b_neg) && (srcB != '0);
                     neg_r_reg <= a_neg;
                     cnt_reg   <= '0;
                     busy_reg  <= 1'b1;
                     state_reg <= CALC;
                  end else begin
                     result_reg <= quick_res;
                     zero_reg   <= (quick_res == '0);
                     done_reg   <= 1'b1;
                  end
               end
            end
            CALC: begin
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == {SW{1'b1}})
                  state_reg <= FIN;
            end
            FIN: begin
               result_reg <= fin_res;
               zero_reg   <= (fin_res == '0);
               done_reg   <= 1'b1;
               busy_reg   <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;
   assign zero   = zero_reg;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, request to accept an operation.
REQ-005 The module SHALL have port op, input, 4, operation select.
REQ-006 The module SHALL have ports srcA and srcB, input, WIDTH each, operands.
REQ-007 The module SHALL have port busy, output, 1, high while a multi-cycle operation is in progress.
REQ-008 The module SHALL have port done, output, 1, one-cycle pulse marking a new result.
REQ-009 The module SHALL have port result, output, WIDTH, registered result.
REQ-010 The module SHALL have port zero, output, 1, high when result is all zeros.

Function
REQ-011 op encoding SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed, result 1/0), 6 sltu, 7 sll (amount srcB[log2(WIDTH)-1:0]), 8 mul (low WIDTH bits), 9 mulhu (high WIDTH bits, unsigned), 10 divu, 11 remu, 12 div (signed), 13 rem (signed); 14-15 SHALL produce result 0.
REQ-012 FSM states SHALL be IDLE, CALC, FIN; an operation is accepted only at a rising edge where state is IDLE and start is 1.
REQ-013 Ops 0-7 and 14-15: at the accepting edge, result and zero SHALL load and done SHALL be 1 for the following cycle; state stays IDLE; busy stays 0.
REQ-014 Ops 8-13: the accepting edge SHALL latch srcA, srcB, op, clear an iteration counter and enter CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle on operand magnitudes, for exactly WIDTH edges, then enter FIN.
REQ-016 The FIN edge SHALL apply sign correction (ops 12, 13), load result and zero, pulse done for the following cycle, and return to IDLE.
REQ-017 Multi-cycle latency SHALL be WIDTH+1 edges from accepting edge to result load; busy SHALL be 1 for exactly those WIDTH+1 cycles.
REQ-018 start while busy SHALL be ignored; operand/op changes after acceptance SHALL not affect the result.
REQ-019 start high in the cycle done is high SHALL be accepted (back-to-back, no bubble).
REQ-020 Divide by zero SHALL run full latency and give: divu/div quotient all ones, remu/rem = srcA.
REQ-021 Signed overflow (srcA = most-negative, srcB = -1) SHALL give div = most-negative, rem = 0.
REQ-022 Signed rem SHALL take the sign of srcA; signed div SHALL truncate toward zero.
REQ-023 add/sub/sll SHALL wrap modulo 2^WIDTH; no carry or overflow output exists.
REQ-024 result and zero SHALL hold their value between loads; done SHALL be 0 except the single cycle after a load.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, result 0, zero 1, done 0, busy 0, counter 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the first accepting edge after rst_n rises SHALL behave as from power-up.

Verification
REQ-027 WIDTH=32, reset then add 5,7 -> result 12, zero 0, done high exactly one cycle after accepting edge, busy never high.
REQ-028 sub 9,9 -> result 0, zero 1; slt 0xFFFFFFFF,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; sll 1,35 -> 8.
REQ-029 mul 0xFFFFFFFF,3 -> 0xFFFFFFFD; mulhu same operands -> 0x00000002; busy high 33 cycles, done pulse 33 edges after acceptance.
REQ-030 div -7,2 -> 0xFFFFFFFD; rem -7,2 -> 0xFFFFFFFF; divu 100,0 -> 0xFFFFFFFF; remu 100,0 -> 100; div 0x80000000,0xFFFFFFFF -> 0x80000000, rem -> 0.
REQ-031 During a divu, hold start high with op add and change srcA -> ignored, divu result correct; assert rst_n low at iteration 10 -> busy/done 0 and result 0 at once, no done pulse; next add works normally.
REQ-032 WIDTH=8 instance: mul 15,17 -> 0xFF, mulhu -> 0x00, latency 9 edges; divu 200,7 -> 28, remu -> 4.
